fetch_unit: RTL and testbench

Instruction fetch sequencer that drives the instruction word consumed by the main control decoder and datapath. It holds the program counter and runs a request/ready handshake with instruction memory. It presents each fetched word with a valid/ack handshake, then advances to PC+4 or redirects to a branch target when the instruction is consumed. It sits between instruction memory and the decode stage; `instr[6:0]` is the opcode field fed to the control decoder.

---
 rtl/fetch_if.sv | 28 ++
 rtl/fetch_unit.sv | 135 +++++++++++++
 tb/tb_fetch_unit.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/fetch_if.sv
// Fetch bus between the fetch sequencer, instruction memory and decode.
// master: the fetch unit; slave: memory/decode side (or a testbench).
interface fetch_if #(
    parameter int PC_WIDTH    = 32,
    parameter int INSTR_WIDTH = 32
);
    logic                   imem_req;
    logic [PC_WIDTH-1:0]    imem_addr;
    logic                   imem_ready;
    logic [INSTR_WIDTH-1:0] imem_rdata;
    logic [INSTR_WIDTH-1:0] instr;
    logic                   instr_valid;
    logic                   instr_ack;
    logic                   branch_taken;
    logic [PC_WIDTH-1:0]    branch_target;
    logic [PC_WIDTH-1:0]    pc;
    logic                   misalign;

    modport master (
        output imem_req, imem_addr, instr, instr_valid, pc, misalign,
        input  imem_ready, imem_rdata, instr_ack, branch_taken, branch_target
    );

    modport slave (
        input  imem_req, imem_addr, instr, instr_valid, pc, misalign,
        output imem_ready, imem_rdata, instr_ack, branch_taken, branch_target
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: holds the PC, requests words from instruction
// memory, presents them to decode with valid/ack, then advances or redirects.
// Optional macro FETCH_MISALIGN_TRAP_EN: a taken branch to a non-word-aligned
// target sets a sticky misalign flag and halts fetch until reset. Without it
// the low two target bits are dropped and misalign is tied low.
module fetch_unit #(
    parameter int                 PC_WIDTH    = 32,
    parameter int                 INSTR_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic    clk,
    input  logic    reset,
    fetch_if.master bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        HALT = 2'd3
`endif
    } state_t;

    state_t                 state_q, state_d;
    logic [PC_WIDTH-1:0]    pc_q, pc_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic                   req_q, req_d;
    logic                   valid_q, valid_d;
    logic [PC_WIDTH-1:0]    pc_plus4;
    logic [PC_WIDTH-1:0]    redirect_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic                   misalign_q, misalign_d;
`endif

    // Sequential PC wraps naturally at 2^PC_WIDTH.
    assign pc_plus4 = pc_q + {{(PC_WIDTH-3){1'b0}}, 3'd4};

`ifdef FETCH_MISALIGN_TRAP_EN
    // Trap build keeps the raw target so the offending address is visible.
    assign redirect_pc = bus.branch_target;
`else
    // Non-trap build silently word-aligns the target.
    assign redirect_pc = bus.branch_target & {{(PC_WIDTH-2){1'b1}}, 2'b00};
`endif

    // Next-state and next-output logic; outputs are registered so req/valid
    // change only on edges.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        req_d   = req_q;
        valid_d = valid_q;
`ifdef FETCH_MISALIGN_TRAP_EN
        misalign_d = misalign_q;
`endif
        case (state_q)
            IDLE: begin
                state_d = REQ;
                req_d   = 1'b1;
            end
            REQ: begin
                if (bus.imem_ready) begin
                    instr_d = bus.imem_rdata;
                    state_d = HOLD;
                    req_d   = 1'b0;
                    valid_d = 1'b1;
                end
            end
            HOLD: begin
                if (bus.instr_ack) begin
                    valid_d = 1'b0;
                    state_d = REQ;
                    req_d   = 1'b1;
                    pc_d    = bus.branch_taken ? redirect_pc : pc_plus4;
`ifdef FETCH_MISALIGN_TRAP_EN
                    if (bus.branch_taken && (bus.branch_target[1:0] != 2'b00)) begin
                        state_d    = HALT;
                        req_d      = 1'b0;
                        misalign_d = 1'b1;
                    end
`endif
                end
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            HALT: begin
                req_d   = 1'b0;
                valid_d = 1'b0;
            end
`endif
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
                valid_d = 1'b0;
            end
        endcase
    end

    // State registers with synchronous reset; reset abandons any fetch.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            req_q   <= req_d;
            valid_q <= valid_d;
`ifdef FETCH_MISALIGN_TRAP_EN
            misalign_q <= misalign_d;
`endif
        end
    end

    assign bus.imem_req    = req_q;
    assign bus.imem_addr   = pc_q;
    assign bus.pc          = pc_q;
    assign bus.instr       = instr_q;
    assign bus.instr_valid = valid_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    assign bus.misalign    = misalign_q;
`else
    assign bus.misalign    = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: expected fetch addresses and captured
// instruction words go into scoreboard queues as stimulus is driven and are
// popped when the DUT presents a request or a valid instruction.
module tb_fetch_unit;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;

    logic [31:0] exp_addr[$];
    logic [31:0] exp_instr[$];
    logic [31:0] e;

    always #5 clk = ~clk;

    fetch_if #(.PC_WIDTH(32), .INSTR_WIDTH(32)) bus ();

    fetch_unit #(.PC_WIDTH(32), .INSTR_WIDTH(32), .RESET_PC(32'h0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.imem_ready = 1'b0;
        bus.instr_ack = 1'b0;
        bus.branch_taken = 1'b0;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        bus.imem_rdata = '0;
        bus.branch_target = '0;
        do_reset();
        reset = 1'b1;
        step();
        total++; if (bus.pc !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h exp=0", bus.pc); end
        total++; if (bus.imem_addr !== 32'h0) begin bad++; $display("FAIL rst_addr got=%h exp=0", bus.imem_addr); end
        total++; if (bus.instr !== 32'h0) begin bad++; $display("FAIL rst_instr got=%h exp=0", bus.instr); end
        total++; if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b exp=0", bus.imem_req); end
        total++; if (bus.instr_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", bus.instr_valid); end
        total++; if (bus.misalign !== 1'b0) begin bad++; $display("FAIL rst_misalign got=%b exp=0", bus.misalign); end
    endtask

    // ready/ack tied high: addresses 0,4,8 on alternate cycles
    task automatic test_stream();
        do_reset();
        bus.imem_ready = 1'b1;
        bus.instr_ack = 1'b1;
        bus.imem_rdata = 32'h0000_0033;
        exp_addr = '{32'h0, 32'h4, 32'h8};
        exp_instr.delete();
        for (int c = 0; c < 6; c++) begin
            step();
            if (bus.instr_valid) begin
                total++;
                if (exp_instr.size() == 0) begin bad++; $display("FAIL stream_instr unexpected valid instr=%h", bus.instr); end
                else begin
                    e = exp_instr.pop_front();
                    if (bus.instr !== e) begin bad++; $display("FAIL stream_instr got=%h exp=%h", bus.instr, e); end
                end
                total++;
                if (bus.instr[6:0] !== 7'b0110011) begin bad++; $display("FAIL stream_opcode got=%b exp=0110011", bus.instr[6:0]); end
            end
            if (bus.imem_req) begin
                total++;
                if (exp_addr.size() == 0) begin bad++; $display("FAIL stream_addr unexpected req addr=%h", bus.imem_addr); end
                else begin
                    e = exp_addr.pop_front();
                    if (bus.imem_addr !== e) begin bad++; $display("FAIL stream_addr got=%h exp=%h", bus.imem_addr, e); end
                end
                if (bus.imem_ready) exp_instr.push_back(bus.imem_rdata);
            end
        end
        bus.instr_ack = 1'b0;
        total++;
        if (exp_addr.size() != 0 || exp_instr.size() != 0) begin
            bad++; $display("FAIL stream_drain got addr_left=%0d instr_left=%0d exp=0", exp_addr.size(), exp_instr.size());
        end
    endtask

    // memory stall in REQ, then ack withheld in HOLD, then branch redirect
    task automatic test_stall_hold_branch();
        do_reset();
        bus.imem_ready = 1'b1;
        bus.imem_rdata = 32'h0000_0013;
        step();                          // REQ @0
        step();                          // HOLD
        bus.imem_ready = 1'b0;
        bus.instr_ack = 1'b1;
        step();                          // REQ @4
        bus.instr_ack = 1'b0;
        for (int c = 0; c < 3; c++) begin
            total++; if (bus.imem_req !== 1'b1) begin bad++; $display("FAIL stall_req c=%0d got=%b exp=1", c, bus.imem_req); end
            total++; if (bus.imem_addr !== 32'h4) begin bad++; $display("FAIL stall_addr c=%0d got=%h exp=4", c, bus.imem_addr); end
            total++; if (bus.instr_valid !== 1'b0) begin bad++; $display("FAIL stall_valid c=%0d got=%b exp=0", c, bus.instr_valid); end
            if (c < 2) step();
        end
        bus.imem_ready = 1'b1;
        bus.imem_rdata = 32'h0000_2003;
        exp_instr.push_back(32'h0000_2003);
        step();                          // capture
        bus.imem_rdata = 32'hDEAD_BEEF;  // must be ignored while holding
        bus.branch_taken = 1'b1;         // no ack: no redirect
        bus.branch_target = 32'h200;
        e = exp_instr.pop_front();
        for (int c = 0; c < 4; c++) begin
            total++; if (bus.instr !== e) begin bad++; $display("FAIL hold_instr c=%0d got=%h exp=%h", c, bus.instr, e); end
            total++; if (bus.instr_valid !== 1'b1) begin bad++; $display("FAIL hold_valid c=%0d got=%b exp=1", c, bus.instr_valid); end
            total++; if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL hold_req c=%0d got=%b exp=0", c, bus.imem_req); end
            total++; if (bus.pc !== 32'h4) begin bad++; $display("FAIL hold_pc c=%0d got=%h exp=4", c, bus.pc); end
            step();
        end
        bus.instr_ack = 1'b1;
        bus.branch_target = 32'h100;
        exp_addr.push_back(32'h100);
        step();
        bus.instr_ack = 1'b0;
        bus.branch_taken = 1'b0;
        e = exp_addr.pop_front();
        total++; if (bus.imem_addr !== e || bus.imem_req !== 1'b1) begin
            bad++; $display("FAIL branch_addr got=%h req=%b exp=%h req=1", bus.imem_addr, bus.imem_req, e);
        end
        total++; if (bus.instr !== 32'h0000_2003) begin bad++; $display("FAIL ack_keeps_instr got=%h exp=00002003", bus.instr); end
    endtask

    // PC wrap and reset asserted mid-request
    task automatic test_wrap_reset();
        bus.imem_ready = 1'b1;
        bus.imem_rdata = 32'h0000_0013;
        step();                          // HOLD @0x100
        bus.instr_ack = 1'b1;
        bus.branch_taken = 1'b1;
        bus.branch_target = 32'hFFFF_FFFC;
        step();                          // REQ @FFFFFFFC
        bus.branch_taken = 1'b0;
        total++; if (bus.imem_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_pre got=%h exp=fffffffc", bus.imem_addr); end
        step();                          // HOLD
        step();                          // REQ @0
        total++; if (bus.imem_addr !== 32'h0 || bus.imem_req !== 1'b1) begin
            bad++; $display("FAIL wrap_addr got=%h req=%b exp=0 req=1", bus.imem_addr, bus.imem_req);
        end
        bus.instr_ack = 1'b0;
        bus.imem_ready = 1'b0;
        step();                          // still REQ @0
        bus.instr_ack = 1'b1;
        bus.imem_ready = 1'b1;
        step();                          // HOLD
        step();                          // REQ @4, mid-request
        bus.instr_ack = 1'b0;
        bus.imem_ready = 1'b0;
        total++; if (bus.imem_addr !== 32'h4) begin bad++; $display("FAIL midreq_addr got=%h exp=4", bus.imem_addr); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        total++; if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL midreq_rst_req got=%b exp=0", bus.imem_req); end
        total++; if (bus.pc !== 32'h0) begin bad++; $display("FAIL midreq_rst_pc got=%h exp=0", bus.pc); end
        total++; if (bus.instr !== 32'h0) begin bad++; $display("FAIL midreq_rst_instr got=%h exp=0", bus.instr); end
        step();
        total++; if (bus.imem_req !== 1'b1) begin bad++; $display("FAIL rst_release_req got=%b exp=1", bus.imem_req); end
    endtask

    // acked branch to 0x102
    task automatic test_misalign();
        do_reset();
        bus.imem_ready = 1'b1;
        step();                          // REQ
        step();                          // HOLD
        bus.instr_ack = 1'b1;
        bus.branch_taken = 1'b1;
        bus.branch_target = 32'h102;
        step();
        bus.instr_ack = 1'b0;
        bus.branch_taken = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        for (int c = 0; c < 4; c++) begin
            total++; if (bus.misalign !== 1'b1) begin bad++; $display("FAIL trap_flag c=%0d got=%b exp=1", c, bus.misalign); end
            total++; if (bus.pc !== 32'h102) begin bad++; $display("FAIL trap_pc c=%0d got=%h exp=102", c, bus.pc); end
            total++; if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0) begin
                bad++; $display("FAIL trap_halt c=%0d got req=%b valid=%b exp=0/0", c, bus.imem_req, bus.instr_valid);
            end
            bus.instr_ack = 1'b1;
            step();
        end
        bus.instr_ack = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        total++; if (bus.misalign !== 1'b0) begin bad++; $display("FAIL trap_clear got=%b exp=0", bus.misalign); end
`else
        total++; if (bus.imem_addr !== 32'h100) begin bad++; $display("FAIL align_addr got=%h exp=100", bus.imem_addr); end
        total++; if (bus.misalign !== 1'b0) begin bad++; $display("FAIL align_flag got=%b exp=0", bus.misalign); end
        total++; if (bus.imem_req !== 1'b1) begin bad++; $display("FAIL align_req got=%b exp=1", bus.imem_req); end
`endif
    endtask

    initial begin
        bus.imem_ready = 1'b0;
        bus.imem_rdata = '0;
        bus.instr_ack = 1'b0;
        bus.branch_taken = 1'b0;
        bus.branch_target = '0;
        test_reset();
        test_stream();
        test_stall_hold_branch();
        test_wrap_reset();
        test_misalign();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
